// File: rtl/input_conditioner.sv
// Purpose: synchronize and debounce the coin/advance/clear buttons, keep a 0..15 credit count, sync the state switches.
// Latency: 2 cycles for estado_sync; DEB_CYCLES+2 edges from a raw button change to its pulse and the credit update.
// Backpressure: none; ena low freezes debounce and credit state and forces every pulse output to 0.
module input_conditioner #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       btn_coin,
  input  logic       btn_avance,
  input  logic       btn_borrar,
  input  logic [2:0] sw_estado,
  output logic [3:0] credito,
  output logic       avance_pulse,
  output logic       coin_pulse,
  output logic       rechazo,
  output logic       saturado,
  output logic [2:0] estado_sync
);

  // Button slots: 0 = coin, 1 = avance, 2 = borrar.
  localparam int NB = 3;
  localparam int B_COIN = 0;
  localparam int B_AV   = 1;
  localparam int B_CLR  = 2;
  // Counter value on the edge where the last required mismatch is seen.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [NB-1:0]    r_btn_s1;
  logic [NB-1:0]    r_btn_s2;
  logic [2:0]       r_sw_s1;
  logic [2:0]       r_sw_s2;
  logic [NB-1:0]    r_stable;
  logic [CNT_W-1:0] r_cnt [NB];
  logic [3:0]       r_credit;
  logic             r_coin_pulse;
  logic             r_av_pulse;
  logic             r_rechazo;
  logic             r_saturado;

  logic [NB-1:0]    w_flip;
  logic [NB-1:0]    w_rise;
  logic             w_add;
  logic             w_sub;
  logic             w_clr;
  logic             w_rej;
  logic             w_sat;
  logic [3:0]       w_credit_nxt;

  // Two-flop synchronizers; these keep running while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_btn_s1 <= {btn_borrar, btn_avance, btn_coin};
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= sw_estado;
      r_sw_s2  <= r_sw_s1;
    end
  end

  // Detect the edge on which a stable level will flip, and whether it flips upward.
  always_comb begin
    w_flip = '0;
    w_rise = '0;
    for (int i = 0; i < NB; i++) begin
      w_flip[i] = (r_btn_s2[i] != r_stable[i]) && (r_cnt[i] == DEB_LAST);
      w_rise[i] = w_flip[i] && r_btn_s2[i];
    end
  end

  // Debounce: count consecutive mismatches, adopt the synced level after DEB_CYCLES of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= '0;
      for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
    end else if (ena) begin
      for (int i = 0; i < NB; i++) begin
        if (r_btn_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_flip[i]) begin
          r_stable[i] <= r_btn_s2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Credit arithmetic: clear wins; an advance only consumes when credit is nonzero.
  always_comb begin
    w_add = w_rise[B_COIN];
    w_sub = w_rise[B_AV] && (r_credit != 4'd0);
    w_clr = w_rise[B_CLR];
    w_credit_nxt = r_credit;
    if (w_clr) begin
      w_credit_nxt = 4'd0;
    end else if (w_add && !w_sub) begin
      if (r_credit != 4'd15) w_credit_nxt = r_credit + 4'd1;
    end else if (w_sub && !w_add) begin
      w_credit_nxt = r_credit - 4'd1;
    end
    w_rej = w_rise[B_AV] && (r_credit == 4'd0) && !w_clr;
    w_sat = w_rise[B_COIN] && (r_credit == 4'd15) && !w_rise[B_AV] && !w_clr;
  end

  // Register credit and the one-cycle event pulses on the edge the stable level rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit     <= '0;
      r_coin_pulse <= 1'b0;
      r_av_pulse   <= 1'b0;
      r_rechazo    <= 1'b0;
      r_saturado   <= 1'b0;
    end else if (ena) begin
      r_credit     <= w_credit_nxt;
      r_coin_pulse <= w_rise[B_COIN];
      r_av_pulse   <= w_rise[B_AV];
      r_rechazo    <= w_rej;
      r_saturado   <= w_sat;
    end else begin
      r_coin_pulse <= 1'b0;
      r_av_pulse   <= 1'b0;
      r_rechazo    <= 1'b0;
      r_saturado   <= 1'b0;
    end
  end

  // Gating with ena keeps a pulse registered just before ena fell from leaking out.
  assign credito      = r_credit;
  assign coin_pulse   = r_coin_pulse & ena;
  assign avance_pulse = r_av_pulse & ena;
  assign rechazo      = r_rechazo & ena;
  assign saturado     = r_saturado & ena;
  assign estado_sync  = r_sw_s2;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEB_CYCLES = 4.
// Inputs change just after a falling edge; outputs are sampled on falling edges.
module tb_input_conditioner;

  localparam int DEB = 4;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       btn_coin;
  logic       btn_avance;
  logic       btn_borrar;
  logic [2:0] sw_estado;
  logic [3:0] credito;
  logic       avance_pulse;
  logic       coin_pulse;
  logic       rechazo;
  logic       saturado;
  logic [2:0] estado_sync;

  int n_assert = 0;
  int n_fail   = 0;

  input_conditioner #(.DEB_CYCLES(DEB), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .btn_coin     (btn_coin),
    .btn_avance   (btn_avance),
    .btn_borrar   (btn_borrar),
    .sw_estado    (sw_estado),
    .credito      (credito),
    .avance_pulse (avance_pulse),
    .coin_pulse   (coin_pulse),
    .rechazo      (rechazo),
    .saturado     (saturado),
    .estado_sync  (estado_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drop all buttons and let them settle; no pulse may appear meanwhile
  // (this also catches a pulse lasting more than one cycle).
  task automatic release_all(input string tag);
    int hits;
    hits = 0;
    btn_coin   = 1'b0;
    btn_avance = 1'b0;
    btn_borrar = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (coin_pulse || avance_pulse || rechazo || saturado) hits++;
    end
    chk({tag, "_release_quiet"}, hits, 0);
  endtask

  // Press the given buttons together; the event is visible DEB+2 falling edges later.
  task automatic press(input string tag, input logic c, input logic a, input logic b,
                       input logic [3:0] e_cred, input logic e_coin, input logic e_av,
                       input logic e_rej, input logic e_sat);
    btn_coin   = c;
    btn_avance = a;
    btn_borrar = b;
    tick(DEB + 1);
    chk({tag, "_early"}, {28'd0, coin_pulse, avance_pulse, rechazo, saturado}, 32'd0);
    tick(1);
    chk({tag, "_credito"}, credito, e_cred);
    chk({tag, "_pulses"}, {28'd0, coin_pulse, avance_pulse, rechazo, saturado},
        {28'd0, e_coin, e_av, e_rej, e_sat});
    release_all(tag);
  endtask

  initial begin
    int hits;
    rst_n      = 1'b0;
    ena        = 1'b1;
    btn_coin   = 1'b0;
    btn_avance = 1'b0;
    btn_borrar = 1'b0;
    sw_estado  = 3'b101;

    // Reset state
    tick(3);
    chk("reset_credito", credito, 4'd0);
    chk("reset_pulses", {28'd0, coin_pulse, avance_pulse, rechazo, saturado}, 32'd0);
    chk("reset_estado", estado_sync, 3'b000);

    // Release and check the 2-cycle switch synchronizer latency
    rst_n = 1'b1;
    tick(1);
    chk("estado_lat1", estado_sync, 3'b000);
    tick(1);
    chk("estado_lat2", estado_sync, 3'b101);

    // Clean coin press: pulse exactly DEB+2 edges after the raw change
    press("coin1", 1, 0, 0, 4'd1, 1, 0, 0, 0);

    // Advance glitch of 3 cycles is rejected
    btn_avance = 1'b1;
    tick(3);
    btn_avance = 1'b0;
    hits = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (avance_pulse || rechazo) hits++;
    end
    chk("glitch3_nopulse", hits, 0);
    chk("glitch3_credito", credito, 4'd1);

    // Coin high for exactly DEB cycles is accepted once
    btn_coin = 1'b1;
    tick(4);
    btn_coin = 1'b0;
    hits = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (coin_pulse) hits++;
    end
    chk("pulse4_count", hits, 1);
    chk("pulse4_credito", credito, 4'd2);

    // Clear alone, then advance at zero credit
    press("clr_a", 0, 0, 1, 4'd0, 0, 0, 0, 0);
    press("av_zero", 0, 1, 0, 4'd0, 0, 1, 1, 0);

    // Sixteen coins: saturate at 15, saturado only on the 16th
    for (int i = 1; i <= 16; i++) begin
      press("sat_coin", 1, 0, 0, (i > 15) ? 4'd15 : 4'(i), 1, 0, 0, (i == 16));
    end

    // Coin + advance at 15: both pulses, credit holds, no saturado
    press("both15", 1, 1, 0, 4'd15, 1, 1, 0, 0);

    // Coin + advance at 0: credit 1, rechazo, both pulses
    press("clr_b", 0, 0, 1, 4'd0, 0, 0, 0, 0);
    press("both0", 1, 1, 0, 4'd1, 1, 1, 1, 0);

    // Build up to 7, then clear together with a coin
    for (int i = 2; i <= 7; i++) begin
      press("to7", 1, 0, 0, 4'(i), 1, 0, 0, 0);
    end
    press("clr_coin", 1, 0, 1, 4'd0, 1, 0, 0, 0);

    // ena low: no debounce progress, no pulses, switches still synchronized
    ena       = 1'b0;
    btn_coin  = 1'b1;
    sw_estado = 3'b010;
    tick(1);
    chk("ena0_estado_lat1", estado_sync, 3'b101);
    tick(1);
    chk("ena0_estado_lat2", estado_sync, 3'b010);
    hits = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (coin_pulse) hits++;
    end
    chk("ena0_nopulse", hits, 0);
    chk("ena0_credito", credito, 4'd0);
    // Debounce resumes from a zero count with the synced level already high
    ena = 1'b1;
    tick(DEB - 1);
    chk("ena1_early", coin_pulse, 1'b0);
    tick(1);
    chk("ena1_pulse", coin_pulse, 1'b1);
    chk("ena1_credito", credito, 4'd1);
    release_all("ena1");

    // Reset mid-debounce of an advance press aborts immediately
    btn_avance = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_credito", credito, 4'd0);
    chk("rst_mid_estado", estado_sync, 3'b000);
    chk("rst_mid_pulses", {28'd0, coin_pulse, avance_pulse, rechazo, saturado}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    // Button still held: pulse only after DEB+2 further cycles
    tick(DEB + 1);
    chk("rst_rel_early", {30'd0, avance_pulse, rechazo}, 32'd0);
    tick(1);
    chk("rst_rel_pulse", {30'd0, avance_pulse, rechazo}, 32'd3);
    chk("rst_rel_credito", credito, 4'd0);
    release_all("rst_rel");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
